// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared encodings, FSM states and address-split helpers for dcache_stage
package dcache_pkg;

  // ldSt_enable encodings; 2'b11 is treated like LS_NONE by the stage
  localparam logic [1:0] LS_NONE  = 2'b00;
  localparam logic [1:0] LS_LOAD  = 2'b01;
  localparam logic [1:0] LS_STORE = 2'b10;

  // Cache-stage FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_STORE   = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  // Word offset inside a line (wpl is a power of two)
  function automatic logic [31:0] addr_offset(input logic [31:0] addr, input int unsigned wpl);
    return addr & (wpl - 1);
  endfunction

  // Line index (lines and wpl are powers of two)
  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int unsigned lines,
                                             input int unsigned wpl);
    return (addr / wpl) & (lines - 1);
  endfunction

  // Tag: everything above the offset and index fields
  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int unsigned lines,
                                           input int unsigned wpl);
    return addr / (wpl * lines);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - flop-based valid/tag/data storage with combinational lookup
module dcache_array
  import dcache_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int LINES  = 8,
  parameter int WPL    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [DATA_W-1:0] read_word,
  input  logic              word_we,
  input  logic [ADDR_W-1:0] word_addr,
  input  logic [DATA_W-1:0] word_data,
  input  logic              tag_set,
  input  logic [ADDR_W-1:0] tag_addr
);

  localparam int OFF_W = $clog2(WPL);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int WORDS = LINES * WPL;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags  [LINES];
  logic [DATA_W-1:0] words [WORDS];

  logic [IDX_W-1:0] lk_idx;
  logic [OFF_W-1:0] lk_off;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] wr_idx;
  logic [OFF_W-1:0] wr_off;
  logic [IDX_W-1:0] tg_idx;
  logic [TAG_W-1:0] tg_tag;

  // Split the lookup, word-write and tag-set addresses into their fields
  always_comb begin
    lk_idx = IDX_W'(addr_index(32'(lookup_addr), LINES, WPL));
    lk_off = OFF_W'(addr_offset(32'(lookup_addr), WPL));
    lk_tag = TAG_W'(addr_tag(32'(lookup_addr), LINES, WPL));
    wr_idx = IDX_W'(addr_index(32'(word_addr), LINES, WPL));
    wr_off = OFF_W'(addr_offset(32'(word_addr), WPL));
    tg_idx = IDX_W'(addr_index(32'(tag_addr), LINES, WPL));
    tg_tag = TAG_W'(addr_tag(32'(tag_addr), LINES, WPL));
  end

  // Combinational hit detection and word read
  always_comb begin
    hit       = valid[lk_idx] && (tags[lk_idx] == lk_tag);
    read_word = words[{lk_idx, lk_off}];
  end

  // Valid bits: cleared by reset, set only once a line is completely filled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (tag_set) begin
      valid[tg_idx] <= 1'b1;
    end
  end

  // Tag storage, written together with the valid bit
  always_ff @(posedge clk) begin
    if (tag_set) begin
      tags[tg_idx] <= tg_tag;
    end
  end

  // Data storage, written by fill beats and store hits
  always_ff @(posedge clk) begin
    if (word_we) begin
      words[{wr_idx, wr_off}] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_stage.sv
// rtl/dcache_stage.sv - direct-mapped write-through cache stage; DCACHE_STATS_EN adds hit/miss counters
module dcache_stage
  import dcache_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int REG_W  = 3,
  parameter int ROB_W  = 3,
  parameter int LINES  = 8,
  parameter int WPL    = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_cache,
  input  logic              valid_input,
  input  logic [1:0]        ldSt_enable,
  input  logic [ADDR_W-1:0] tlb_result,
  input  logic [DATA_W-1:0] dataReg,
  input  logic [REG_W-1:0]  destReg_addr_input,
  input  logic              we_input,
  input  logic [1:0]        bp_input,
  input  logic [ROB_W-1:0]  tail_rob_input,
  output logic [DATA_W-1:0] cache_result,
  output logic [REG_W-1:0]  destReg_addr_output,
  output logic              we_output,
  output logic [1:0]        bp_output,
  output logic [ROB_W-1:0]  tail_rob_output,
  output logic              valid_output,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
`endif
);

  localparam int OFF_W = $clog2(WPL);

  state_t state;

  // Request captured at the accepting edge and replayed in RESPOND
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;
  logic [DATA_W-1:0] pend_word;
  logic [REG_W-1:0]  pend_dest;
  logic              pend_we;
  logic [1:0]        pend_bp;
  logic [ROB_W-1:0]  pend_tail;
  logic [OFF_W-1:0]  beat_cnt;

  logic              accept;
  logic              is_load;
  logic              is_store;
  logic              beat_done;
  logic              last_beat;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] lookup_addr;
  logic              hit;
  logic [DATA_W-1:0] read_word;
  logic              word_we;
  logic [DATA_W-1:0] word_data;
  logic              tag_set;

  // Request decode; the array looks at the live address in IDLE and the pending one otherwise
  always_comb begin
    accept      = valid_input & enable_cache & ~stall;
    is_load     = (ldSt_enable == LS_LOAD);
    is_store    = (ldSt_enable == LS_STORE);
    beat_done   = mem_req & mem_ack;
    last_beat   = (beat_cnt == OFF_W'(WPL - 1));
    line_base   = {tlb_result[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    lookup_addr = (state == ST_IDLE) ? tlb_result : pend_addr;
  end

  // Array write controls: fill beats always write, a store writes only if its line is resident
  always_comb begin
    word_we   = 1'b0;
    word_data = mem_rdata;
    tag_set   = 1'b0;
    if (state == ST_FILL) begin
      word_we = beat_done;
      tag_set = beat_done & last_beat;
    end else if (state == ST_STORE) begin
      word_we   = beat_done & hit;
      word_data = mem_wdata;
    end
  end

  dcache_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LINES  (LINES),
    .WPL    (WPL)
  ) u_array (
    .clk         (clk),
    .reset       (reset),
    .lookup_addr (lookup_addr),
    .hit         (hit),
    .read_word   (read_word),
    .word_we     (word_we),
    .word_addr   (mem_addr),
    .word_data   (word_data),
    .tag_set     (tag_set),
    .tag_addr    (pend_addr)
  );

  // FSM, memory handshake, pending capture and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= ST_IDLE;
      stall               <= 1'b0;
      mem_req             <= 1'b0;
      mem_we              <= 1'b0;
      mem_addr            <= '0;
      mem_wdata           <= '0;
      cache_result        <= '0;
      destReg_addr_output <= '0;
      we_output           <= 1'b0;
      bp_output           <= '0;
      tail_rob_output     <= '0;
      valid_output        <= 1'b0;
      pend_addr           <= '0;
      pend_data           <= '0;
      pend_word           <= '0;
      pend_dest           <= '0;
      pend_we             <= 1'b0;
      pend_bp             <= '0;
      pend_tail           <= '0;
      beat_cnt            <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_load && hit) begin
              cache_result        <= read_word;
              destReg_addr_output <= destReg_addr_input;
              we_output           <= we_input;
              bp_output           <= bp_input;
              tail_rob_output     <= tail_rob_input;
              valid_output        <= 1'b1;
            end else if (is_load || is_store) begin
              pend_addr    <= tlb_result;
              pend_data    <= dataReg;
              pend_word    <= dataReg;
              pend_dest    <= destReg_addr_input;
              pend_we      <= we_input;
              pend_bp      <= bp_input;
              pend_tail    <= tail_rob_input;
              valid_output <= 1'b0;
              stall        <= 1'b1;
              mem_req      <= 1'b1;
              beat_cnt     <= '0;
              if (is_load) begin
                state    <= ST_FILL;
                mem_we   <= 1'b0;
                mem_addr <= line_base;
              end else begin
                state     <= ST_STORE;
                mem_we    <= 1'b1;
                mem_addr  <= tlb_result;
                mem_wdata <= dataReg;
              end
            end else begin
              cache_result        <= tlb_result;
              destReg_addr_output <= destReg_addr_input;
              we_output           <= we_input;
              bp_output           <= bp_input;
              tail_rob_output     <= tail_rob_input;
              valid_output        <= 1'b1;
            end
          end else if (enable_cache) begin
            valid_output <= 1'b0;
          end
        end

        ST_FILL: begin
          if (beat_done) begin
            if (beat_cnt == pend_addr[OFF_W-1:0]) begin
              pend_word <= mem_rdata;
            end
            if (last_beat) begin
              mem_req <= 1'b0;
              state   <= ST_RESPOND;
            end else begin
              beat_cnt <= beat_cnt + OFF_W'(1);
              mem_addr <= mem_addr + ADDR_W'(1);
            end
          end
        end

        ST_STORE: begin
          if (beat_done) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= ST_RESPOND;
          end
        end

        ST_RESPOND: begin
          if (enable_cache) begin
            cache_result        <= pend_word;
            destReg_addr_output <= pend_dest;
            we_output           <= pend_we;
            bp_output           <= pend_bp;
            tail_rob_output     <= pend_tail;
            valid_output        <= 1'b1;
            stall               <= 1'b0;
            state               <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
          stall <= 1'b0;
        end
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  // Saturating hit/miss counters for accepted loads; stores are not counted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (accept && is_load) begin
      if (hit) begin
        if (hit_count != {CNT_W{1'b1}}) hit_count <= hit_count + CNT_W'(1);
      end else begin
        if (miss_count != {CNT_W{1'b1}}) miss_count <= miss_count + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_stage.sv
// tb/tb_dcache_stage.sv - self-checking bench for dcache_stage (directed table, corner sequences, random vs model)
module tb_dcache_stage;
  import dcache_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int REG_W  = 3;
  localparam int ROB_W  = 3;
  localparam int LINES  = 8;
  localparam int WPL    = 4;
  localparam int CNT_W  = 2;
  localparam int LAT_MAX = 300;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable_cache;
  logic              valid_input;
  logic [1:0]        ldSt_enable;
  logic [ADDR_W-1:0] tlb_result;
  logic [DATA_W-1:0] dataReg;
  logic [REG_W-1:0]  destReg_addr_input;
  logic              we_input;
  logic [1:0]        bp_input;
  logic [ROB_W-1:0]  tail_rob_input;
  logic [DATA_W-1:0] cache_result;
  logic [REG_W-1:0]  destReg_addr_output;
  logic              we_output;
  logic [1:0]        bp_output;
  logic [ROB_W-1:0]  tail_rob_output;
  logic              valid_output;
  logic              stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;
`endif

  dcache_stage #(
    .DATA_W (DATA_W), .ADDR_W (ADDR_W), .REG_W (REG_W), .ROB_W (ROB_W),
    .LINES  (LINES),  .WPL    (WPL),    .CNT_W (CNT_W)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .enable_cache        (enable_cache),
    .valid_input         (valid_input),
    .ldSt_enable         (ldSt_enable),
    .tlb_result          (tlb_result),
    .dataReg             (dataReg),
    .destReg_addr_input  (destReg_addr_input),
    .we_input            (we_input),
    .bp_input            (bp_input),
    .tail_rob_input      (tail_rob_input),
    .cache_result        (cache_result),
    .destReg_addr_output (destReg_addr_output),
    .we_output           (we_output),
    .bp_output           (bp_output),
    .tail_rob_output     (tail_rob_output),
    .valid_output        (valid_output),
    .stall               (stall),
    .mem_req             (mem_req),
    .mem_we              (mem_we),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .mem_ack             (mem_ack),
    .mem_rdata           (mem_rdata)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count           (hit_count),
    .miss_count          (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ack_pct = 100;
  bit force_ack = 1'b0;

  logic [15:0] mem [65536];
  logic [16:0] beat_q [$];

  bit mvalid [LINES];
  int mtag   [LINES];

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] data;
    logic [2:0]  dest;
    logic        w;
    logic [1:0]  bp;
    logic [2:0]  tail;
    logic [15:0] exp_res;
    int          beats;
    logic [15:0] first;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory responder: decides ack on the falling edge; a beat is committed when req&ack
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack   = force_ack | (mem_req && ($urandom_range(0, 99) < ack_pct));
      mem_rdata = mem[mem_addr];
      if (mem_req && mem_ack) begin
        beat_q.push_back({mem_we, mem_addr});
        if (mem_we) mem[mem_addr] = mem_wdata;
      end
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] data,
                        input logic [2:0] dest, input logic w, input logic [1:0] bp,
                        input logic [2:0] tail, output int lat);
    @(negedge clk);
    beat_q.delete();
    ldSt_enable = op; tlb_result = addr; dataReg = data;
    destReg_addr_input = dest; we_input = w; bp_input = bp; tail_rob_input = tail;
    valid_input = 1'b1; enable_cache = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    valid_input = 1'b0;
    while (!valid_output && lat < LAT_MAX) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic check_op(input string nm, input logic [1:0] op, input logic [15:0] exp_res,
                          input logic [2:0] dest, input logic w, input logic [1:0] bp,
                          input logic [2:0] tail, input int beats, input logic [15:0] first,
                          input int lat, input bit exact);
    int exp_lat;
    bit ok;
    logic [15:0] a;
    exp_lat = (beats == 0) ? 1 : beats + 2;
    chk({nm, "_timeout"}, 32'(lat < LAT_MAX), 1);
    chk({nm, "_valid"}, 32'(valid_output), 1);
    chk({nm, "_result"}, 32'(cache_result), 32'(exp_res));
    chk({nm, "_side"}, {destReg_addr_output, we_output, bp_output, tail_rob_output},
        {dest, w, bp, tail});
    chk({nm, "_stall"}, 32'(stall), 0);
    chk({nm, "_nbeats"}, beat_q.size(), beats);
    if (beats > 0) begin
      ok = 1'b1;
      for (int i = 0; i < beat_q.size() && i < beats; i++) begin
        a = first + 16'(i);
        if (beat_q[i] !== {op == LS_STORE, a}) ok = 1'b0;
      end
      chk({nm, "_beat_addr"}, 32'(ok), 1);
    end
    if (exact) chk({nm, "_lat"}, lat, exp_lat);
    else       chk({nm, "_lat_min"}, 32'(lat >= exp_lat), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    valid_input = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [15:0] held;
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'hA5A5;

    reset = 1'b1; enable_cache = 1'b0; valid_input = 1'b0; ldSt_enable = LS_NONE;
    tlb_result = '0; dataReg = '0; destReg_addr_input = '0; we_input = 1'b0;
    bp_input = '0; tail_rob_input = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {stall, mem_req, mem_we, valid_output}, 0);
    chk("reset_data", {cache_result, destReg_addr_output, we_output, bp_output, tail_rob_output}, 0);
    chk("reset_mem", {mem_addr, mem_wdata}, 0);
    reset = 1'b0;

    // Directed table with zero-wait memory: exact latencies
    tbl[0]  = '{LS_LOAD,  16'h0012, 16'h0000, 3'd1, 1'b1, 2'd0, 3'd1, 16'hA5B7, 4, 16'h0010};
    tbl[1]  = '{LS_LOAD,  16'h0012, 16'h0000, 3'd2, 1'b1, 2'd1, 3'd2, 16'hA5B7, 0, 16'h0000};
    tbl[2]  = '{LS_STORE, 16'h0011, 16'hBEEF, 3'd3, 1'b0, 2'd2, 3'd3, 16'hBEEF, 1, 16'h0011};
    tbl[3]  = '{LS_LOAD,  16'h0011, 16'h0000, 3'd4, 1'b1, 2'd3, 3'd4, 16'hBEEF, 0, 16'h0000};
    tbl[4]  = '{LS_STORE, 16'h0040, 16'h1111, 3'd6, 1'b0, 2'd0, 3'd5, 16'h1111, 1, 16'h0040};
    tbl[5]  = '{LS_LOAD,  16'h0040, 16'h0000, 3'd7, 1'b1, 2'd1, 3'd6, 16'h1111, 4, 16'h0040};
    tbl[6]  = '{LS_NONE,  16'h1234, 16'h0000, 3'd5, 1'b1, 2'd0, 3'd7, 16'h1234, 0, 16'h0000};
    tbl[7]  = '{2'b11,    16'h4321, 16'h9999, 3'd2, 1'b0, 2'd2, 3'd0, 16'h4321, 0, 16'h0000};
    tbl[8]  = '{LS_LOAD,  16'h0013, 16'h0000, 3'd1, 1'b1, 2'd3, 3'd1, 16'hA5B6, 0, 16'h0000};
    tbl[9]  = '{LS_LOAD,  16'h0092, 16'h0000, 3'd3, 1'b1, 2'd1, 3'd2, 16'hA537, 4, 16'h0090};
    tbl[10] = '{LS_LOAD,  16'h0012, 16'h0000, 3'd6, 1'b0, 2'd0, 3'd3, 16'hA5B7, 4, 16'h0010};
    tbl[11] = '{LS_LOAD,  16'h0041, 16'h0000, 3'd0, 1'b1, 2'd2, 3'd4, 16'hA5E4, 0, 16'h0000};
    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].dest, tbl[i].w, tbl[i].bp, tbl[i].tail, lat);
      check_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].exp_res, tbl[i].dest, tbl[i].w,
               tbl[i].bp, tbl[i].tail, tbl[i].beats, tbl[i].first, lat, 1'b1);
    end

    // enable_cache low in IDLE: every output holds, nothing is accepted
    run_op(LS_NONE, 16'h5A5A, 16'h0, 3'd5, 1'b1, 2'd1, 3'd2, lat);
    held = cache_result;
    enable_cache = 1'b0; valid_input = 1'b1; ldSt_enable = LS_LOAD; tlb_result = 16'h0777;
    beat_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("hold_valid", 32'(valid_output), 1);
    chk("hold_result", 32'(cache_result), 32'(held));
    chk("hold_idle", {stall, mem_req, 30'(beat_q.size())}, 0);
    enable_cache = 1'b1; valid_input = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("bubble_valid", 32'(valid_output), 0);
    chk("bubble_result", 32'(cache_result), 32'(held));

    // RESPOND waits for enable_cache
    beat_q.delete();
    ldSt_enable = LS_LOAD; tlb_result = 16'h0070; destReg_addr_input = 3'd4; we_input = 1'b1;
    valid_input = 1'b1; enable_cache = 1'b1;
    @(posedge clk); @(negedge clk);
    valid_input = 1'b0; enable_cache = 1'b0;
    repeat (WPL + 3) @(posedge clk);
    @(negedge clk);
    chk("respond_hold", {stall, valid_output, mem_req}, 3'b100);
    chk("respond_beats", beat_q.size(), WPL);
    enable_cache = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("respond_out", {stall, valid_output, cache_result}, {1'b0, 1'b1, mem[16'h0070]});

    // Reset after the second fill ack: line abandoned, late acks ignored, full refill
    @(negedge clk);
    beat_q.delete();
    ldSt_enable = LS_LOAD; tlb_result = 16'h0030; valid_input = 1'b1; enable_cache = 1'b1;
    @(posedge clk); @(negedge clk);
    valid_input = 1'b0;
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b1;
    force_ack = 1'b1;
    chk("midfill_beats", beat_q.size(), 2);
    @(negedge clk);
    chk("midfill_reset", {stall, mem_req, valid_output}, 0);
    reset = 1'b0;
    for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("late_ack_ignored", {stall, mem_req, valid_output}, 0);
    end
    force_ack = 1'b0;
    run_op(LS_LOAD, 16'h0030, 16'h0, 3'd2, 1'b1, 2'd2, 3'd6, lat);
    check_op("refill", LS_LOAD, 16'hA595, 3'd2, 1'b1, 2'd2, 3'd6, 4, 16'h0030, lat, 1'b1);

    // Random traffic with random memory wait states against the line model
    do_reset();
    ack_pct = 60;
    for (int n = 0; n < 150; n++) begin
      int r, idx, tg, beats;
      logic [1:0] op;
      logic [15:0] addr, data, exp;
      logic [2:0] dest, tail;
      logic [1:0] bp;
      logic w;
      r = $urandom_range(0, 9);
      op = (r < 2) ? LS_NONE : (r == 2) ? 2'b11 : (r < 7) ? LS_LOAD : LS_STORE;
      addr = 16'($urandom_range(0, 255));
      data = 16'($urandom);
      dest = 3'($urandom); tail = 3'($urandom); bp = 2'($urandom); w = 1'($urandom);
      idx = (int'(addr) / WPL) % LINES;
      tg  = int'(addr) / (WPL * LINES);
      beats = 0;
      exp = addr;
      if (op == LS_LOAD) begin
        exp = mem[addr];
        if (!(mvalid[idx] && mtag[idx] == tg)) beats = WPL;
      end else if (op == LS_STORE) begin
        exp = data;
        beats = 1;
      end
      run_op(op, addr, data, dest, w, bp, tail, lat);
      check_op($sformatf("rnd%0d", n), op, exp, dest, w, bp, tail, beats,
               (op == LS_LOAD) ? (addr & 16'hFFFC) : addr, lat, beats == 0);
      if (op == LS_LOAD) begin
        mvalid[idx] = 1'b1;
        mtag[idx] = tg;
      end
    end

`ifdef DCACHE_STATS_EN
    do_reset();
    ack_pct = 100;
    run_op(LS_LOAD, 16'h0012, 16'h0, 3'd0, 1'b0, 2'd0, 3'd0, lat);
    run_op(LS_LOAD, 16'h0012, 16'h0, 3'd0, 1'b0, 2'd0, 3'd0, lat);
    run_op(LS_LOAD, 16'h0013, 16'h0, 3'd0, 1'b0, 2'd0, 3'd0, lat);
    run_op(LS_LOAD, 16'h0010, 16'h0, 3'd0, 1'b0, 2'd0, 3'd0, lat);
    chk("stats_miss", 32'(miss_count), 1);
    chk("stats_hit", 32'(hit_count), 3);
    run_op(LS_LOAD, 16'h0011, 16'h0, 3'd0, 1'b0, 2'd0, 3'd0, lat);
    chk("stats_hit_sat", 32'(hit_count), 3);
    run_op(LS_STORE, 16'h0050, 16'h2222, 3'd0, 1'b0, 2'd0, 3'd0, lat);
    chk("stats_store_uncounted", 32'(miss_count), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
